// File: rtl/hp_controller_if.sv
// Event and status bundle between the game logic and the HP keeper.
// Latency: none; this is wiring only.
// Backpressure: none; events are single-cycle pulses or levels, status is sampled every pixel.
interface hp_controller_if;
   logic       frame_tick;
   logic       game_start;
   logic       hit;
   logic       heal;
   logic [1:0] hp;
   logic       HP_exist;
   logic       dead;
   logic       invuln;

   // Event source side (collision logic / game control)
   modport master (
      output frame_tick, game_start, hit, heal,
      input  hp, HP_exist, dead, invuln
   );

   // HP keeper side
   modport slave (
      input  frame_tick, game_start, hit, heal,
      output hp, HP_exist, dead, invuln
   );
endinterface

// File: rtl/hp_controller.sv
// Player hit-point keeper: turns start/hit/heal events into hp, heart visibility and invulnerability blink.
// Latency: an event sampled on cycle n shows on the registered outputs from cycle n+1.
// Backpressure: none; edges are detected, so a held request produces exactly one event.
module hp_controller #(
   parameter int MAX_HP        = 3,
   parameter int INVULN_FRAMES = 60,
   parameter int BLINK_FRAMES  = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   hp_controller_if.slave   bus
);

   localparam int IW = $clog2(INVULN_FRAMES + 1);
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES);
   localparam logic [IW-1:0] INV_ONE    = IW'(1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES);
   localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
   localparam logic [1:0]    HP_MAX     = 2'(MAX_HP);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALIVE  = 2'd1,
      INVULN = 2'd2,
      DEAD   = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    hp_r, hp_nxt;
   logic          exist_r, exist_nxt;
   logic [IW-1:0] inv_cnt, inv_nxt;
   logic [BW-1:0] blink_cnt, blink_nxt;
   logic          start_q, hit_q, heal_q;
   logic          start_edge, hit_edge, heal_edge;
   logic          dead_w, invuln_w;

   assign start_edge = bus.game_start & ~start_q;
   assign hit_edge   = bus.hit        & ~hit_q;
   assign heal_edge  = bus.heal       & ~heal_q;

   // State, datapath and edge-history registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         hp_r      <= 2'd0;
         exist_r   <= 1'b0;
         inv_cnt   <= '0;
         blink_cnt <= '0;
         start_q   <= 1'b0;
         hit_q     <= 1'b0;
         heal_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         hp_r      <= hp_nxt;
         exist_r   <= exist_nxt;
         inv_cnt   <= inv_nxt;
         blink_cnt <= blink_nxt;
         start_q   <= bus.game_start;
         hit_q     <= bus.hit;
         heal_q    <= bus.heal;
      end
   end

   // Next state plus next hp / visibility / window counters
   always_comb begin
      state_nxt = state;
      hp_nxt    = hp_r;
      exist_nxt = exist_r;
      inv_nxt   = inv_cnt;
      blink_nxt = blink_cnt;
      if (start_edge) begin
         // Restart wins over everything else in the same cycle
         state_nxt = ALIVE;
         hp_nxt    = HP_MAX;
         exist_nxt = 1'b1;
         inv_nxt   = '0;
         blink_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               exist_nxt = 1'b0;
            end
            ALIVE: begin
               exist_nxt = 1'b1;
               if (hit_edge) begin
                  // A simultaneous heal is dropped
                  if (hp_r <= 2'd1) begin
                     hp_nxt    = 2'd0;
                     state_nxt = DEAD;
                  end else begin
                     hp_nxt    = hp_r - 2'd1;
                     state_nxt = INVULN;
                     inv_nxt   = INV_LOAD;
                     blink_nxt = BLINK_LOAD;
                     exist_nxt = 1'b0;
                  end
               end else if (heal_edge && (hp_r < HP_MAX)) begin
                  hp_nxt = hp_r + 2'd1;
               end
            end
            INVULN: begin
               if (heal_edge && (hp_r < HP_MAX)) begin
                  hp_nxt = hp_r + 2'd1;
               end
               if (bus.frame_tick) begin
                  if (inv_cnt <= INV_ONE) begin
                     // Window over: hearts come back solid
                     inv_nxt   = '0;
                     state_nxt = ALIVE;
                     exist_nxt = 1'b1;
                  end else begin
                     inv_nxt = inv_cnt - INV_ONE;
                     if (blink_cnt <= BLINK_ONE) begin
                        exist_nxt = ~exist_r;
                        blink_nxt = BLINK_LOAD;
                     end else begin
                        blink_nxt = blink_cnt - BLINK_ONE;
                     end
                  end
               end
            end
            DEAD: begin
               // Hearts stay "visible" so the renderer shows the empty bar
               hp_nxt    = 2'd0;
               exist_nxt = 1'b1;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Status flags decoded from the registered state
   always_comb begin
      dead_w   = (state == DEAD);
      invuln_w = (state == INVULN);
   end

   assign bus.hp       = hp_r;
   assign bus.HP_exist = exist_r;
   assign bus.dead     = dead_w;
   assign bus.invuln   = invuln_w;

endmodule

// File: tb/tb_hp_controller.sv
`timescale 1ns/1ps
// Directed bench for hp_controller: a scoreboard queue holds the expected status for each driven cycle.
// Latency: each expectation is checked 1 ns after the clock edge that consumes its stimulus.
// Backpressure: not applicable; the bench drives every cycle.
module tb_hp_controller;

   localparam int INV   = 60;
   localparam int BLINK = 4;

   typedef struct {
      string      tag;
      logic [1:0] hp;
      logic       ex;
      logic       dd;
      logic       inv;
   } exp_t;

   logic Clk;
   logic Reset;
   int   checks;
   int   errors;
   exp_t sb[$];

   hp_controller_if bus();

   hp_controller #(
      .MAX_HP(3),
      .INVULN_FRAMES(INV),
      .BLINK_FRAMES(BLINK)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus)
   );

   // 100 MHz clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic push_exp(input string tag, input logic [1:0] hp, input logic ex,
                           input logic dd, input logic inv);
      exp_t e;
      e.tag = tag; e.hp = hp; e.ex = ex; e.dd = dd; e.inv = inv;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: got 0 entries required >=1");
         return;
      end
      e = sb.pop_front();
      checks++;
      assert (bus.hp === e.hp) else begin
         errors++;
         $error("FAIL %s hp: got %0d required %0d", e.tag, bus.hp, e.hp);
      end
      checks++;
      assert (bus.HP_exist === e.ex) else begin
         errors++;
         $error("FAIL %s HP_exist: got %b required %b", e.tag, bus.HP_exist, e.ex);
      end
      checks++;
      assert (bus.dead === e.dd) else begin
         errors++;
         $error("FAIL %s dead: got %b required %b", e.tag, bus.dead, e.dd);
      end
      checks++;
      assert (bus.invuln === e.inv) else begin
         errors++;
         $error("FAIL %s invuln: got %b required %b", e.tag, bus.invuln, e.inv);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, expect the given status after the next rising edge
   task automatic step(input logic fr, input logic st, input logic hi, input logic he,
                       input string tag, input logic [1:0] hp, input logic ex,
                       input logic dd, input logic inv);
      @(negedge Clk);
      bus.frame_tick = fr;
      bus.game_start = st;
      bus.hit        = hi;
      bus.heal       = he;
      push_exp(tag, hp, ex, dd, inv);
      @(posedge Clk);
      #1;
      sb_check();
   endtask

   // Full invulnerability window, one frame_tick per cycle, hp constant throughout
   task automatic run_window(input string tag, input logic [1:0] hp);
      for (int k = 1; k <= INV; k++) begin
         if (k == INV)
            step(1'b1, 1'b0, 1'b0, 1'b0, tag, hp, 1'b1, 1'b0, 1'b0);
         else
            step(1'b1, 1'b0, 1'b0, 1'b0, tag, hp, 1'(((k / BLINK) % 2)), 1'b0, 1'b1);
      end
   endtask

   // Asynchronous reset pulse between clock edges, outputs checked before any edge
   task automatic mid_cycle_reset(input string tag);
      #2;
      Reset = 1'b1;
      #1;
      push_exp(tag, 2'd0, 1'b0, 1'b0, 1'b0);
      sb_check();
      #0.5;
      Reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Reset  = 1'b1;
      bus.frame_tick = 1'b0;
      bus.game_start = 1'b0;
      bus.hit        = 1'b0;
      bus.heal       = 1'b0;

      // Reset state
      repeat (2) @(posedge Clk);
      #1;
      push_exp("reset", 2'd0, 1'b0, 1'b0, 1'b0);
      sb_check();
      @(negedge Clk);
      Reset = 1'b0;

      // IDLE ignores hit and heal
      step(0, 0, 1, 0, "idle_hit",  2'd0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 1, "idle_heal", 2'd0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 0, "idle_rel",  2'd0, 1'b0, 1'b0, 1'b0);

      // 1. start, then asynchronous reset mid-cycle, then start again
      step(0, 1, 0, 0, "start1",  2'd3, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, "start1r", 2'd3, 1'b1, 1'b0, 1'b0);
      mid_cycle_reset("async_rst");
      step(0, 0, 0, 0, "post_rst", 2'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1, 0, 0, "start2",   2'd3, 1'b1, 1'b0, 1'b0);
      // held start level: no second event
      step(0, 1, 0, 0, "start_hold", 2'd3, 1'b1, 1'b0, 1'b0);

      // 2. hit, then the blink pattern and end of window
      step(0, 0, 1, 0, "hit1",  2'd2, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 0, "hit1r", 2'd2, 1'b0, 1'b0, 1'b1);
      run_window("window1", 2'd2);

      // 3. hits ignored in INVULN, heal saturates
      step(0, 1, 0, 0, "start3", 2'd3, 1'b1, 1'b0, 1'b0);
      step(0, 0, 1, 0, "hit3",   2'd2, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, "inv_hit_lo", 2'd2, 1'b0, 1'b0, 1'b1);
         step(0, 0, 1, 0, "inv_hit_hi", 2'd2, 1'b0, 1'b0, 1'b1);
      end
      // tick together with a hit edge: tick counted, hit ignored
      step(0, 0, 0, 0, "inv_rel",     2'd2, 1'b0, 1'b0, 1'b1);
      step(1, 0, 1, 0, "inv_tickhit", 2'd2, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 1, "inv_heal1",   2'd3, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 0, "inv_heal1r",  2'd3, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 1, "inv_heal2",   2'd3, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 0, "inv_heal2r",  2'd3, 1'b0, 1'b0, 1'b1);

      // 6. start and hit together in INVULN: restart wins
      step(0, 1, 1, 0, "inv_start_hit", 2'd3, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, "inv_start_rel", 2'd3, 1'b1, 1'b0, 1'b0);

      // 4. held hit: one decrement only
      for (int i = 0; i < 100; i++)
         step(0, 0, 1, 0, "hit_hold", 2'd2, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 0, "hit_hold_rel", 2'd2, 1'b0, 1'b0, 1'b1);
      run_window("window2", 2'd2);
      step(0, 0, 1, 0, "hit4", 2'd1, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 0, "hit4r", 2'd1, 1'b0, 1'b0, 1'b1);
      run_window("window3", 2'd1);
      // held heal in ALIVE: at most +1
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 1, "heal_hold", 2'd2, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, "heal_hold_rel", 2'd2, 1'b1, 1'b0, 1'b0);

      // 5. reach hp=1, then hit+heal together kills
      step(0, 0, 1, 0, "hit5",  2'd1, 1'b0, 1'b0, 1'b1);
      step(0, 0, 0, 0, "hit5r", 2'd1, 1'b0, 1'b0, 1'b1);
      run_window("window4", 2'd1);
      step(0, 0, 1, 1, "hit_heal_die", 2'd0, 1'b1, 1'b1, 1'b0);
      step(0, 0, 0, 0, "dead_rel",     2'd0, 1'b1, 1'b1, 1'b0);
      step(0, 0, 1, 0, "dead_hit",     2'd0, 1'b1, 1'b1, 1'b0);
      step(0, 0, 0, 1, "dead_heal",    2'd0, 1'b1, 1'b1, 1'b0);
      step(1, 0, 0, 0, "dead_tick",    2'd0, 1'b1, 1'b1, 1'b0);
      step(0, 1, 0, 0, "dead_start",   2'd3, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, "dead_startr",  2'd3, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a window aborts it
      step(0, 0, 1, 0, "hit6",  2'd2, 1'b0, 1'b0, 1'b1);
      step(1, 0, 0, 0, "tick6", 2'd2, 1'b0, 1'b0, 1'b1);
      mid_cycle_reset("win_rst");
      step(1, 0, 0, 0, "win_rst_idle", 2'd0, 1'b0, 1'b0, 1'b0);
      step(0, 1, 0, 0, "win_rst_start", 2'd3, 1'b1, 1'b0, 1'b0);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
